// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchroniser, stability counter and a
// registered one-cycle pulse for each accepted press.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter bit KEY_ACTIVE_LOW  = 1'b1,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic key_pulse
);

   localparam logic             IDLE_LEVEL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             s1, s2;
   logic             pressed;
   logic             pulse_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= IDLE_LEVEL;
         s2 <= IDLE_LEVEL;
      end else begin
         s1 <= key;
         s2 <= s1;
      end
   end

   assign pressed = KEY_ACTIVE_LOW ? ~s2 : s2;

   // The pulse is registered on the same edge that accepts the press, so it is
   // visible during the cycle right after the stable state becomes PRESSED.
   always_comb begin
      state_next = state;
      cnt_next   = '0;
      pulse_next = 1'b0;
      if (pressed != (state == PRESSED)) begin
         if (cnt == CNT_LAST) begin
            state_next = pressed ? PRESSED : RELEASED;
            pulse_next = pressed;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RELEASED;
         cnt       <= '0;
         key_pulse <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         key_pulse <= pulse_next;
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (DEBOUNCE_CYCLES=8, active-low key): expected pulse
// cycles are queued when a press is driven and matched as pulses appear.
module tb_key_debounce;

   localparam int DC = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key = 1'b1;
   logic key_pulse;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;
   int exp_q[$];

   key_debounce #(.DEBOUNCE_CYCLES(DC), .KEY_ACTIVE_LOW(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .key_pulse (key_pulse)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press driven now becomes visible as a pulse DC+2 edges later.
   task automatic press_expect();
      key = 1'b0;
      exp_q.push_back(cyc + DC + 2);
   endtask

   always @(negedge clk) begin
      if (key_pulse === 1'b1) begin
         if (exp_q.size() > 0) chk("pulse_cycle", cyc, exp_q.pop_front());
         else                  chk("spurious_pulse", int'(key_pulse), 0);
      end
   end

   initial begin
      // 1: reset with key low, then release key before debounce completes
      @(negedge clk);
      rst = 1'b1;
      key = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("rst_pulse", int'(key_pulse), 0);
      end
      rst = 1'b0;
      tick(1);
      chk("post_rst_pulse", int'(key_pulse), 0);
      key = 1'b1;
      tick(20);
      chk("t1_missing", exp_q.size(), 0);

      // 2: press held 40 cycles, one pulse only; release gives none
      press_expect();
      tick(40);
      key = 1'b1;
      tick(20);
      chk("t2_missing", exp_q.size(), 0);

      // 3: bounce every 3 cycles, never accepted
      for (int i = 0; i < 20; i++) begin
         key = ~key;
         tick(3);
      end
      key = 1'b1;
      tick(20);
      chk("t3_missing", exp_q.size(), 0);

      // 4: press, release, press
      press_expect();
      tick(20);
      key = 1'b1;
      tick(20);
      press_expect();
      tick(20);
      key = 1'b1;
      tick(20);
      chk("t4_missing", exp_q.size(), 0);

      // 5: reset 5 cycles after the pulse while key stays low
      press_expect();
      tick(DC + 2 + 5);
      chk("t5_first_missing", exp_q.size(), 0);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick(1);
         chk("t5_rst_pulse", int'(key_pulse), 0);
      end
      rst = 1'b0;
      exp_q.push_back(cyc + DC + 2);
      tick(25);
      key = 1'b1;
      tick(20);
      chk("t5_missing", exp_q.size(), 0);

      // 6: low for DC-1 cycles is rejected, DC cycles is accepted
      key = 1'b0;
      tick(DC - 1);
      key = 1'b1;
      tick(20);
      chk("t6_short_missing", exp_q.size(), 0);
      press_expect();
      tick(DC);
      key = 1'b1;
      tick(20);
      chk("t6_missing", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=stalled exp=finished");
      $fatal(1, "timeout");
   end

endmodule
